// File: rtl/sm_pkg.sv
// sm_pkg: shared widths, vector length, FSM states and Q16.16 limits for the division stage
package sm_pkg;
    localparam int VEC_LEN   = 16;
    localparam int FRAC_BITS = 16;
    localparam int D_W       = 8;
    localparam int X_W       = 16;
    localparam int Q_W       = 32;
    localparam int DIV_W     = D_W + FRAC_BITS;
    localparam int CNT_W     = $clog2(VEC_LEN);
    localparam int STEP_W    = $clog2(DIV_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        OUT  = 2'd3
    } sm_state_t;
endpackage

// File: rtl/sm_if.sv
// sm_if: divisor stream, dividend sideband and quotient stream bundled for the division stage
interface sm_if;
    import sm_pkg::*;
    logic [X_W-1:0] s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [D_W-1:0] s_axis_dividend_tdata;
    logic           s_axis_dividend_tvalid;
    logic [Q_W-1:0] m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_dividend_tdata, s_axis_dividend_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_dividend_tdata, s_axis_dividend_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/sm_serial_divider.sv
// sm_serial_divider: 24-bit by 16-bit unsigned restoring divider, one quotient bit per cycle MSB first
module sm_serial_divider
    import sm_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [X_W-1:0]   divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);
    logic [X_W-1:0]    rem;
    logic [X_W-1:0]    dvs;
    logic [STEP_W-1:0] cnt;
    logic [X_W:0]      trial;
    logic [X_W:0]      diff;
    logic              fit;

    // trial subtraction of the next dividend bit; done flags the step that completes the quotient
    always_comb begin
        trial = {rem, quotient[DIV_W-1]};
        diff  = trial - {1'b0, dvs};
        fit   = trial >= {1'b0, dvs};
        done  = cnt == STEP_W'(1);
    end

    // quotient register doubles as the dividend shift register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            quotient <= '0;
        end else if (start) begin
            rem      <= '0;
            dvs      <= divisor;
            cnt      <= STEP_W'(DIV_W);
            quotient <= dividend;
        end else if (cnt != '0) begin
            rem      <= fit ? diff[X_W-1:0] : trial[X_W-1:0];
            quotient <= {quotient[DIV_W-2:0], fit};
            cnt      <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/sm_sys_wrapper.sv
// sm_sys_wrapper: streams Q16.16 quotients D/x with held dividend, sign handling and vector tlast
module sm_sys_wrapper
    import sm_pkg::*;
(
    input logic  aclk,
    input logic  aresetn,
    sm_if.slave  bus
);
    sm_state_t        state;
    logic [D_W-1:0]   d_reg;
    logic [D_W-1:0]   d_eff;
    logic [D_W-1:0]   abs_d;
    logic [X_W-1:0]   abs_x;
    logic [DIV_W-1:0] quotient;
    logic [Q_W-1:0]   q_mag;
    logic [Q_W-1:0]   result;
    logic [Q_W-1:0]   tdata;
    logic [CNT_W-1:0] cnt;
    logic             tvalid;
    logic             tlast;
    logic             take;
    logic             done;
    logic             neg;
    logic             d_neg;
    logic             x_zero;

    assign bus.s_axis_tready = aresetn && state == IDLE;
    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;

    // a dividend arriving with the divisor bypasses the register; magnitudes feed the divider
    always_comb begin
        d_eff  = bus.s_axis_dividend_tvalid ? bus.s_axis_dividend_tdata : d_reg;
        take   = bus.s_axis_tvalid && bus.s_axis_tready;
        abs_d  = d_eff[D_W-1] ? -d_eff : d_eff;
        abs_x  = bus.s_axis_tdata[X_W-1] ? -bus.s_axis_tdata : bus.s_axis_tdata;
        q_mag  = {{(Q_W-DIV_W){1'b0}}, quotient};
        result = x_zero ? (d_neg ? Q_MIN : Q_MAX) : (neg ? -q_mag : q_mag);
    end

    sm_serial_divider u_div (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (take),
        .dividend ({abs_d, {FRAC_BITS{1'b0}}}),
        .divisor  (abs_x),
        .done     (done),
        .quotient (quotient)
    );

    // dividend register, loaded on every sideband strobe
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            d_reg <= '0;
        else if (bus.s_axis_dividend_tvalid)
            d_reg <= bus.s_axis_dividend_tdata;
    end

    // control FSM: accept x, wait for the divider, sign the result, hold it until taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            neg    <= 1'b0;
            d_neg  <= 1'b0;
            x_zero <= 1'b0;
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    neg    <= d_eff[D_W-1] ^ bus.s_axis_tdata[X_W-1];
                    d_neg  <= d_eff[D_W-1];
                    x_zero <= bus.s_axis_tdata == '0;
                    state  <= CALC;
                end
                CALC: if (done) state <= SIGN;
                SIGN: begin
                    tdata  <= result;
                    tlast  <= cnt == LAST_IDX;
                    tvalid <= 1'b1;
                    state  <= OUT;
                end
                OUT: if (bus.m_axis_tready) begin
                    tvalid <= 1'b0;
                    cnt    <= cnt == LAST_IDX ? '0 : cnt + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_sys_wrapper.sv
// tb_sm_sys_wrapper: directed vectors for the D/x division stage with hand-computed quotients
module tb_sm_sys_wrapper;
    import sm_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   idx = 0;

    sm_if bus ();

    sm_sys_wrapper dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] x, input logic load);
        int n = 0;
        @(negedge aclk);
        while (!bus.s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("send_ready", 32'(bus.s_axis_tready), 32'd1);
        bus.s_axis_tdata = x;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_dividend_tdata = d;
        bus.s_axis_dividend_tvalid = load;
        @(posedge aclk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_dividend_tvalid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int ready_hi = 0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge aclk);
            if (bus.m_axis_tvalid) begin
                lat = k;
                break;
            end
            if (bus.s_axis_tready) ready_hi++;
        end
        check("busy_ready_low", 32'(ready_hi), 32'd0);
    endtask

    task automatic op(input string tag, input logic [7:0] d, input logic [15:0] x, input logic load,
                      input logic [31:0] exp_q);
        int lat;
        send(d, x, load);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd26);
        check({tag, "_q"}, bus.m_axis_tdata, exp_q);
        check({tag, "_last"}, 32'(bus.m_axis_tlast), 32'(idx == 15));
        idx = (idx + 1) % 16;
        @(negedge aclk);
        check({tag, "_drop"}, 32'(bus.m_axis_tvalid), 32'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int hits = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge aclk);
            if (bus.m_axis_tvalid) hits++;
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        int lat;
        int errs;
        bus.s_axis_tdata = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_dividend_tdata = '0;
        bus.s_axis_dividend_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_s_ready", 32'(bus.s_axis_tready), 32'd0);
        check("rst_m_valid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst_m_data", bus.m_axis_tdata, 32'd0);
        check("rst_m_last", 32'(bus.m_axis_tlast), 32'd0);
        aresetn = 1'b1;
        #1;
        check("rel_s_ready", 32'(bus.s_axis_tready), 32'd1);

        op("d4_x2", 8'd4, 16'd2, 1'b1, 32'h0002_0000);
        op("dm1_x3", 8'hFF, 16'd3, 1'b1, 32'hFFFF_AAAB);
        op("dm128_xm1", 8'h80, 16'hFFFF, 1'b1, 32'h0080_0000);
        op("d5_x0", 8'd5, 16'd0, 1'b1, 32'h7FFF_FFFF);
        op("dm5_x0", 8'hFB, 16'd0, 1'b1, 32'h8000_0000);

        @(negedge aclk);
        bus.s_axis_dividend_tdata = 8'd7;
        bus.s_axis_dividend_tvalid = 1'b1;
        @(negedge aclk);
        bus.s_axis_dividend_tvalid = 1'b0;
        op("bypass", 8'd3, 16'd1, 1'b1, 32'h0003_0000);
        op("held", 8'd0, 16'd1, 1'b0, 32'h0003_0000);

        bus.m_axis_tready = 1'b0;
        send(8'd2, 16'd4, 1'b1);
        wait_valid(lat);
        check("stall_latency", 32'(lat), 32'd26);
        bus.s_axis_tdata = 16'd1;
        bus.s_axis_tvalid = 1'b1;
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge aclk);
            if (bus.m_axis_tdata !== 32'h0000_8000 || bus.m_axis_tvalid !== 1'b1 ||
                bus.m_axis_tlast !== 1'b0 || bus.s_axis_tready !== 1'b0) errs++;
        end
        check("stall_stable", 32'(errs), 32'd0);
        check("stall_q", bus.m_axis_tdata, 32'h0000_8000);
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        idx = (idx + 1) % 16;
        @(negedge aclk);
        check("stall_drop", 32'(bus.m_axis_tvalid), 32'd0);
        quiet("stall_no_extra", 30);

        send(8'd9, 16'd2, 1'b1);
        repeat (10) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("abort_valid", 32'(bus.m_axis_tvalid), 32'd0);
        check("abort_ready", 32'(bus.s_axis_tready), 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("abort_rel_ready", 32'(bus.s_axis_tready), 32'd1);
        quiet("abort_quiet", 30);
        idx = 0;

        for (int x = 1; x <= 20; x++)
            op("vec", 8'd1, 16'(x), x == 1, 32'(65536 / x));

        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        idx = 0;
        op("d_cleared", 8'd0, 16'd5, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
